// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizing for the AES byte-serial stream controller.
package aes_ctrl_pkg;

   localparam int BLOCK_BYTES = 16;
   localparam int BYTE_W      = 8;
   localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;
   localparam int CNT_W       = $clog2(BLOCK_BYTES);

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_LOAD,
      S_WAIT_VLD,
      S_COLLECT,
      S_WAIT_DONE,
      S_OUT
   } aes_ctrl_state_t;

endpackage

// File: rtl/aes_stream_ctrl_shift128.sv
// 128-bit byte shifter: parallel load, shift left one byte per enable, MSB byte exposed.
// Load has priority over shift; no flow control of its own.
module aes_shift128
   import aes_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [BLOCK_W-1:0] load_dat,
   input  logic               shift,
   input  logic [BYTE_W-1:0]  shift_in,
   output logic [BYTE_W-1:0]  msb_byte,
   output logic [BLOCK_W-1:0] dat
);

   logic [BLOCK_W-1:0] dat_q;
   logic [BLOCK_W-1:0] dat_d;

   always_comb begin
      dat_d = dat_q;
      if (load) begin
         dat_d = load_dat;
      end else if (shift) begin
         dat_d = {dat_q[BLOCK_W-BYTE_W-1:0], shift_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q <= '0;
      end else begin
         dat_q <= dat_d;
      end
   end

   assign msb_byte = dat_q[BLOCK_W-1 -: BYTE_W];
   assign dat      = dat_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Sequences one key/plaintext pair through the byte-serial aes_8_bit core and returns the ciphertext.
// Accept-to-core: 1 reset cycle + 16 load cycles; out_valid holds until out_ready, in_ready only in IDLE.
module aes_stream_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 1024
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_key,
   input  logic [BLOCK_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               err,
   output logic               core_rst,
   output logic [BYTE_W-1:0]  core_key,
   output logic [BYTE_W-1:0]  core_din,
   input  logic [BYTE_W-1:0]  core_dout,
   input  logic               core_dvld,
   input  logic               core_done
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   aes_ctrl_state_t   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [WD_W-1:0]   wd_inc;
   logic              wd_run, wd_hit;
   logic [BYTE_W-1:0] core_key_q, core_key_d;
   logic [BYTE_W-1:0] core_din_q, core_din_d;
   logic              core_rst_q, core_rst_d;
   logic              err_q, err_d;

   logic              sr_load, ser_shift, col_shift;
   logic [BYTE_W-1:0] key_msb, din_msb;
   logic [BLOCK_W-1:0] key_dat_unused, din_dat_unused;
   logic [BYTE_W-1:0] ct_msb_unused;

   aes_shift128 u_key_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (sr_load),
      .load_dat (in_key),
      .shift    (ser_shift),
      .shift_in ('0),
      .msb_byte (key_msb),
      .dat      (key_dat_unused)
   );

   aes_shift128 u_din_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (sr_load),
      .load_dat (in_data),
      .shift    (ser_shift),
      .shift_in ('0),
      .msb_byte (din_msb),
      .dat      (din_dat_unused)
   );

   aes_shift128 u_ct_col (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .load_dat ('0),
      .shift    (col_shift),
      .shift_in (core_dout),
      .msb_byte (ct_msb_unused),
      .dat      (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wd_q       <= '0;
         core_key_q <= '0;
         core_din_q <= '0;
         core_rst_q <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wd_q       <= wd_d;
         core_key_q <= core_key_d;
         core_din_q <= core_din_d;
         core_rst_q <= core_rst_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wd_run  = (TIMEOUT != 0) &&
                (state_q inside {S_WAIT_VLD, S_COLLECT, S_WAIT_DONE});
      wd_inc  = wd_q + 1'b1;
      wd_hit  = wd_run && (wd_inc == WD_W'(TIMEOUT));
      wd_d    = (wd_run && !wd_hit) ? wd_inc : '0;
      case (state_q)
         S_IDLE:      if (in_valid) state_d = S_RST;
         S_RST: begin
            state_d = S_LOAD;
            cnt_d   = '0;
         end
         S_LOAD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BYTE) begin
               state_d = S_WAIT_VLD;
               cnt_d   = '0;
            end
         end
         S_WAIT_VLD: begin
            if (core_dvld) begin
               state_d = S_COLLECT;
               cnt_d   = CNT_W'(1);
            end
         end
         S_COLLECT: begin
            cnt_d = cnt_q + 1'b1;
            // cnt_q == LAST_BYTE is the sixteenth capture; done only counts from here on
            if (cnt_q == LAST_BYTE) begin
               state_d = core_done ? S_OUT : S_WAIT_DONE;
               cnt_d   = '0;
            end
         end
         S_WAIT_DONE: if (core_done) state_d = S_OUT;
         S_OUT:       if (out_ready) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (wd_hit) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      in_ready   = (state_q == S_IDLE);
      out_valid  = (state_q == S_OUT);
      sr_load    = (state_q == S_IDLE) && in_valid;
      // the RST cycle already launches byte 0 so it is on the pins for LOAD cycle 0
      ser_shift  = (state_q == S_RST) || ((state_q == S_LOAD) && (cnt_q != LAST_BYTE));
      col_shift  = ((state_q == S_WAIT_VLD) && core_dvld) || (state_q == S_COLLECT);
      core_rst_d = (state_d == S_IDLE) || (state_d == S_RST);
      core_key_d = ser_shift ? key_msb : '0;
      core_din_d = ser_shift ? din_msb : '0;
      err_d      = wd_hit;
   end

   assign core_key = core_key_q;
   assign core_din = core_din_q;
   assign core_rst = core_rst_q;
   assign err      = err_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl with a behavioural byte-serial core and a cycle timeline scoreboard.
module tb_aes_stream_ctrl;

   localparam int TO  = 64;
   localparam int LAT = 5;

   localparam logic [127:0] SP_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SP_DAT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] SP_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FI_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FI_DAT = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FI_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] G1_KEY = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] G1_DAT = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] G2_KEY = 128'h11111111222222223333333344444444;
   localparam logic [127:0] G2_DAT = 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready;
   logic [127:0] in_key, in_data;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic         err;
   logic         core_rst;
   logic [7:0]   core_key, core_din, core_dout;
   logic         core_dvld, core_done;

   aes_stream_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .core_rst  (core_rst),
      .core_key  (core_key),
      .core_din  (core_din),
      .core_dout (core_dout),
      .core_dvld (core_dvld),
      .core_done (core_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_errs++;
      $display("FAIL %s: got no event expected one within budget (cycle %0d)", name, cyc);
   endtask

   // Stand-in cipher: the two published vectors, anything else a fixed reversible scramble.
   function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d);
      if (k == SP_KEY && d == SP_DAT) return SP_CT;
      if (k == FI_KEY && d == FI_DAT) return FI_CT;
      return k ^ {d[63:0], d[127:64]} ^ 128'hc3c3c3c3_3c3c3c3c_96969696_69696969;
   endfunction

   // Behavioural core. Modes: 0 done with last byte, 1 early done then late done, 2 never valid.
   int           cm_mode = 0;
   int           cm_complete = -1;
   int           cm_phase, cm_n, cm_w;
   logic [127:0] cm_key, cm_dat, cm_ct;

   initial begin
      core_dvld = 1'b0; core_done = 1'b0; core_dout = 8'h00;
      cm_phase = 0; cm_n = 0; cm_w = 0; cm_key = '0; cm_dat = '0; cm_ct = '0;
      forever begin
         @(posedge clk);
         #2;
         if (core_rst === 1'b1) begin
            cm_phase = 0; cm_n = 0; cm_complete = -1;
            core_dvld = 1'b0; core_done = 1'b0; core_dout = 8'h00;
         end else begin
            case (cm_phase)
               0: begin
                  cm_key = {cm_key[119:0], core_key};
                  cm_dat = {cm_dat[119:0], core_din};
                  cm_n++;
                  if (cm_n == 16) begin
                     cm_ct = cipher(cm_key, cm_dat);
                     cm_phase = 1;
                     cm_w = 0;
                  end
               end
               1: begin
                  cm_w++;
                  core_done = (cm_mode == 1 && cm_w == 2);
                  if (cm_mode != 2 && cm_w == LAT) begin
                     core_done = 1'b0;
                     core_dvld = 1'b1;
                     core_dout = cm_ct[127:120];
                     cm_n = 1;
                     cm_phase = 2;
                  end
               end
               2: begin
                  if (cm_n < 16) begin
                     core_dout = cm_ct[127-8*cm_n -: 8];
                     core_dvld = 1'b1;
                     cm_n++;
                     if (cm_mode == 0 && cm_n == 16) begin
                        core_done = 1'b1;
                        cm_complete = cyc;
                     end
                  end else begin
                     core_dvld = 1'b0; core_dout = 8'h00; core_done = 1'b0;
                     cm_w = 0;
                     cm_phase = (cm_mode == 1) ? 3 : 4;
                  end
               end
               3: begin
                  cm_w++;
                  core_done = (cm_w == 10);
                  if (cm_w == 10) begin
                     cm_complete = cyc;
                     cm_phase = 4;
                  end
               end
               default: core_done = 1'b0;
            endcase
         end
      end
   end

   // Timeline scoreboard, evaluated on every falling edge.
   bit           busy = 0, ov_exp = 0, rst_pend = 0, started = 0, err_exp;
   int           acc_c = -1000, abort_c = -1;
   logic [127:0] acc_key, acc_dat;
   logic [127:0] exp_q[$];
   logic [7:0]   exp_k, exp_d;

   initial forever begin
      @(negedge clk);
      if (rst_pend) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_err", err, 0);
         chk("rst_core_rst", core_rst, 1);
         chk("rst_core_key", core_key, 0);
         chk("rst_core_din", core_din, 0);
         chk("rst_out_data", out_data, 0);
      end else if (started) begin
         err_exp = 0;
         if (busy && cyc == abort_c) begin
            err_exp = 1;
            busy = 0;
            void'(exp_q.pop_front());
         end
         if (busy && cm_complete >= 0 && cyc == cm_complete + 1) ov_exp = 1;
         exp_k = 8'h00;
         exp_d = 8'h00;
         if (busy && cyc >= acc_c + 1 && cyc <= acc_c + 16) begin
            exp_k = acc_key[127-8*(cyc-acc_c-1) -: 8];
            exp_d = acc_dat[127-8*(cyc-acc_c-1) -: 8];
         end
         chk("in_ready", in_ready, !busy);
         chk("out_valid", out_valid, ov_exp);
         chk("err", err, err_exp);
         chk("core_rst", core_rst, (!busy || cyc == acc_c));
         chk("core_key", core_key, exp_k);
         chk("core_din", core_din, exp_d);
         if (ov_exp) chk("out_data", out_data, exp_q[0]);
      end
      if (rst) begin
         rst_pend = 1; started = 1; busy = 0; ov_exp = 0;
         exp_q.delete();
      end else begin
         rst_pend = 0;
         if (started) begin
            if (ov_exp && out_ready) begin
               busy = 0; ov_exp = 0;
               void'(exp_q.pop_front());
            end else if (!busy && in_valid) begin
               busy = 1;
               acc_c = cyc + 1;
               abort_c = (cm_mode == 2) ? acc_c + 17 + TO : -1;
               acc_key = in_key;
               acc_dat = in_data;
               exp_q.push_back(cipher(in_key, in_data));
            end
         end
      end
   end

   task automatic await_accept(input bit hold, output int acc);
      acc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc + 1;
            break;
         end
      end
      if (acc < 0) fail_timeout("accept");
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic send(input logic [127:0] k, input logic [127:0] d, input bit hold, output int acc);
      in_key = k;
      in_data = d;
      in_valid = 1'b1;
      await_accept(hold, acc);
   endtask

   task automatic wait_ov(output int t);
      t = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) fail_timeout("out_valid");
   endtask

   int acc, t;
   bit saw_ov;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // SP 800 vector: key bytes 00..0f on the pins, then ciphertext
      cm_mode = 0;
      send(SP_KEY, SP_DAT, 0, acc);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("sp_key_byte", core_key, 128'(k));
      end
      wait_ov(t);
      chk("sp_latency", 128'(t - acc), 128'd37);
      chk("sp_ct", out_data, SP_CT);
      @(negedge clk);
      chk("sp_ov_drop", out_valid, 0);

      // FIPS-197 vector
      @(posedge clk); #1;
      send(FI_KEY, FI_DAT, 0, acc);
      wait_ov(t);
      chk("fips_ct", out_data, FI_CT);

      // Backpressure with a second request already waiting
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(SP_KEY, SP_DAT, 1, acc);
      in_key = FI_KEY;
      in_data = FI_DAT;
      wait_ov(t);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("bp_ct_stable", out_data, SP_CT);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      await_accept(0, acc);
      wait_ov(t);
      chk("bp_second_latency", 128'(t - acc), 128'd37);
      chk("bp_second_ct", out_data, FI_CT);

      // Reset while byte 7 is on the pins
      @(posedge clk); #1;
      send(G1_KEY, G1_DAT, 0, acc);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_core_rst", core_rst, 1);
      chk("midrst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      send(SP_KEY, SP_DAT, 0, acc);
      wait_ov(t);
      chk("midrst_fresh_ct", out_data, SP_CT);

      // Early done ignored, late done completes
      @(posedge clk); #1;
      cm_mode = 1;
      send(G2_KEY, G2_DAT, 0, acc);
      wait_ov(t);
      chk("late_done_latency", 128'(t - acc), 128'd48);
      chk("late_done_ct", out_data, cipher(G2_KEY, G2_DAT));

      // Watchdog on a core that never answers
      @(posedge clk); #1;
      cm_mode = 2;
      send(G1_KEY, G1_DAT, 0, acc);
      t = -1;
      saw_ov = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) saw_ov = 1;
         if (err) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) fail_timeout("watchdog_err");
      chk("wd_err_cycle", 128'(t - acc), 128'd81);
      @(negedge clk);
      chk("wd_err_one_cycle", err, 0);
      chk("wd_idle", in_ready, 1);
      chk("wd_no_out_valid", saw_ov, 0);

      @(posedge clk); #1;
      cm_mode = 0;
      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got still running expected finished");
      n_errs++;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $fatal(1, "simulation time limit reached");
   end

endmodule
